// File: rtl/spram_pkg.sv
// Shared constants and helpers for the pipelined single-port RAM.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package spram_pkg;

  // Deepest supported read pipeline; sizes the outstanding-read counter.
  localparam int MAX_RD_LATENCY = 4;

  // Number of 8-bit lanes in a data word.
  function automatic int byte_lanes(input int dwidth);
    return dwidth / 8;
  endfunction

  // Even parity: the returned bit makes the total count of ones even.
  function automatic logic even_par(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/spram_pipe_if.sv
// Request/response bundle between a requester (master) and spram_pipe (slave).
// Latency: n/a (wires only).
// Backpressure: req_valid/req_ready on requests, resp_valid/resp_ready on read data.
interface spram_pipe_if
  import spram_pkg::*;
#(
  parameter int AWIDTH = 10,
  parameter int DWIDTH = 32
);
  localparam int NB = byte_lanes(DWIDTH);

  logic              req_valid;
  logic              req_ready;
  logic              wren;
  logic [AWIDTH-1:0] address;
  logic [NB-1:0]     byteen;
  logic [DWIDTH-1:0] data;
  logic              par_inject;
  logic              resp_valid;
  logic              resp_ready;
  logic [DWIDTH-1:0] out;
  logic              resp_perr;

  modport master (
    output req_valid, wren, address, byteen, data, par_inject, resp_ready,
    input  req_ready, resp_valid, out, resp_perr
  );

  modport slave (
    input  req_valid, wren, address, byteen, data, par_inject, resp_ready,
    output req_ready, resp_valid, out, resp_perr
  );
endinterface

// File: rtl/spram_resp_fifo.sv
// Response FIFO with fall-through: an entry written into an empty FIFO is visible the same cycle.
// Latency: 0 cycles when empty (bypass), otherwise in-order behind older entries.
// Backpressure: rd_rdy_i stalls the head; the writer must never overflow (no full flag).
module spram_resp_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_vld_i,
  input  logic [WIDTH-1:0] wr_dat_i,
  output logic             rd_vld_o,
  input  logic             rd_rdy_i,
  output logic [WIDTH-1:0] rd_dat_o
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             empty, bypass, push, pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Fall-through head selection and pointer/occupancy next state
  always_comb begin
    empty    = (cnt_q == '0);
    rd_vld_o = !empty || wr_vld_i;
    rd_dat_o = !empty ? mem_q[rd_ptr_q] : (wr_vld_i ? wr_dat_i : '0);
    // An entry arriving at an empty FIFO that is consumed at once never gets stored.
    bypass   = empty && wr_vld_i && rd_rdy_i;
    push     = wr_vld_i && !bypass;
    pop      = !empty && rd_rdy_i;
    wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    cnt_d    = cnt_q;
    if (push && !pop) begin
      cnt_d = cnt_q + CW'(1);
    end else if (!push && pop) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  // Pointers and occupancy clear immediately on reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Entry storage; contents are only meaningful behind valid pointers
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_dat_i;
    end
  end
endmodule

// File: rtl/spram_pipe.sv
// Single-port RAM with byte-enabled writes, pipelined reads and an in-order response FIFO (optional parity: SPRAM_PARITY_EN).
// Latency: read data appears RD_LATENCY cycles after acceptance; writes complete at the acceptance edge.
// Backpressure: req_ready drops once RD_LATENCY+1 reads are outstanding; resp_ready stalls the response FIFO.
module spram_pipe
  import spram_pkg::*;
#(
  parameter int AWIDTH     = 10,
  parameter int NUM_WORDS  = 1024,
  parameter int DWIDTH     = 32,
  parameter int RD_LATENCY = 1
) (
  input  logic       clk,
  input  logic       reset,
  spram_pipe_if.slave bus
);
  localparam int NB         = byte_lanes(DWIDTH);
  localparam int FIFO_DEPTH = RD_LATENCY + 1;
  localparam int CNTW       = $clog2(MAX_RD_LATENCY + 2);
  localparam int RW         = DWIDTH + 1;  // {perr, data}

  logic [DWIDTH-1:0] mem_q [NUM_WORDS];

  logic              addr_ok;
  logic              req_acc, wr_acc, rd_acc, rsp_pop;
  logic [DWIDTH-1:0] rd_word;
  logic              rd_perr;

  logic              stg_vld_q [RD_LATENCY];
  logic [RW-1:0]     stg_dat_q [RD_LATENCY];

  logic [CNTW-1:0]   cnt_q, cnt_d;
  logic [RW-1:0]     fifo_dat;

  // Request decode; out-of-range writes are dropped, out-of-range reads return zero
  always_comb begin
    addr_ok       = (int'(bus.address) < NUM_WORDS);
    bus.req_ready = (cnt_q < CNTW'(RD_LATENCY + 1));
    req_acc       = bus.req_valid && bus.req_ready;
    wr_acc        = req_acc && bus.wren && addr_ok;
    rd_acc        = req_acc && !bus.wren;
    rsp_pop       = bus.resp_valid && bus.resp_ready;
    rd_word       = addr_ok ? mem_q[bus.address] : '0;
  end

  // Byte-masked write; byteen MSB gates byte 0, and memory is never reset
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      for (int j = 0; j < NB; j++) begin
        if (bus.byteen[NB-1-j]) begin
          mem_q[bus.address][8*j +: 8] <= bus.data[8*j +: 8];
        end
      end
    end
  end

`ifdef SPRAM_PARITY_EN
  logic [NB-1:0] par_q [NUM_WORDS];
  logic [NB-1:0] par_calc;

  // Parity tracks every enabled byte; injection flips byte 0's stored bit
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      for (int j = 0; j < NB; j++) begin
        if (bus.byteen[NB-1-j]) begin
          par_q[bus.address][j] <= even_par(bus.data[8*j +: 8]) ^ ((j == 0) && bus.par_inject);
        end
      end
    end
  end

  // Recompute parity of the word being read and flag any lane mismatch
  always_comb begin
    par_calc = '0;
    rd_perr  = 1'b0;
    for (int j = 0; j < NB; j++) begin
      par_calc[j] = even_par(rd_word[8*j +: 8]);
    end
    rd_perr = addr_ok && (par_calc != par_q[bus.address]);
  end
`else
  logic unused_par_inject;
  assign unused_par_inject = bus.par_inject;
  assign rd_perr           = 1'b0;
`endif

  // Read sample register followed by RD_LATENCY-1 plain delay stages
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < RD_LATENCY; i++) begin
        stg_vld_q[i] <= 1'b0;
        stg_dat_q[i] <= '0;
      end
    end else begin
      stg_vld_q[0] <= rd_acc;
      stg_dat_q[0] <= {rd_perr, rd_word};
      for (int i = 1; i < RD_LATENCY; i++) begin
        stg_vld_q[i] <= stg_vld_q[i-1];
        stg_dat_q[i] <= stg_dat_q[i-1];
      end
    end
  end

  // Outstanding reads: in pipeline plus FIFO; accept-and-pop together cancel
  always_comb begin
    cnt_d = cnt_q;
    if (rd_acc && !rsp_pop) begin
      cnt_d = cnt_q + CNTW'(1);
    end else if (!rd_acc && rsp_pop) begin
      cnt_d = cnt_q - CNTW'(1);
    end
  end

  // Counter register, cleared immediately on reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  spram_resp_fifo #(
    .WIDTH (RW),
    .DEPTH (FIFO_DEPTH)
  ) u_resp_fifo (
    .clk      (clk),
    .reset    (reset),
    .wr_vld_i (stg_vld_q[RD_LATENCY-1]),
    .wr_dat_i (stg_dat_q[RD_LATENCY-1]),
    .rd_vld_o (bus.resp_valid),
    .rd_rdy_i (bus.resp_ready),
    .rd_dat_o (fifo_dat)
  );

  assign bus.out       = fifo_dat[DWIDTH-1:0];
  assign bus.resp_perr = fifo_dat[DWIDTH];
endmodule

// File: doc/spram_pipe.md
SPRAM_PIPE -- requirements
Module: spram_pipe

Interface
REQ-001 SHALL have parameter AWIDTH, default 10: word address width.
REQ-002 SHALL have parameter NUM_WORDS, default 1024: storage depth, at most 2**AWIDTH.
REQ-003 SHALL have parameter DWIDTH, default 32: data width, a multiple of 32.
REQ-004 SHALL have parameter RD_LATENCY, default 1, legal range 1..4: cycles from read acceptance to first response availability.
REQ-005 SHALL have port clk, input, 1: sole clock; all state changes on its rising edge.
REQ-006 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-007 SHALL have port req_valid, input, 1: request present.
REQ-008 SHALL have port req_ready, output, 1: request can be accepted.
REQ-009 SHALL have port wren, input, 1: 1 = write, 0 = read.
REQ-010 SHALL have port address, input, AWIDTH: word address.
REQ-011 SHALL have port byteen, input, DWIDTH/8: write byte enables.
REQ-012 SHALL have port data, input, DWIDTH: write data.
REQ-013 SHALL have port par_inject, input, 1: on a write, store inverted parity for byte 0.
REQ-014 SHALL have port resp_valid, output, 1: read data present.
REQ-015 SHALL have port resp_ready, input, 1: consumer accepts read data.
REQ-016 SHALL have port out, output, DWIDTH: read data.
REQ-017 SHALL have port resp_perr, output, 1: parity error flag for the current response.

Function
REQ-018 SHALL accept a request only on a cycle where req_valid and req_ready are both 1.
REQ-019 SHALL, for an accepted write, update the memory at the same edge, with no response.
REQ-020 SHALL have byteen[DWIDTH/8-1-j] gate data byte j (bits 8j+7:8j); byteen MSB gates byte 0.
REQ-021 SHALL leave a byte unchanged when its enable is 0; byteen all 0 SHALL make a write a no-op.
REQ-022 SHALL, for an accepted read, sample memory at the acceptance edge and delay the result RD_LATENCY-1 further pipeline stages before it enters the response FIFO.
REQ-023 SHALL return the new data when a read follows a write to the same address in the next cycle.
REQ-024 SHALL deliver responses in request order; each response is consumed on a cycle with resp_valid and resp_ready both 1.
REQ-025 SHALL hold out and resp_perr stable while resp_valid=1 and resp_ready=0.
REQ-026 SHALL hold the response FIFO at depth RD_LATENCY+1.
REQ-027 SHALL keep an outstanding-read counter, counting reads in the pipeline plus FIFO occupancy.
REQ-028 SHALL drive req_ready = (counter < RD_LATENCY+1), so a FIFO overflow is impossible.
REQ-029 SHALL drive req_ready regardless of wren.
REQ-030 SHALL, on a simultaneous read accept and response pop, leave the counter unchanged.
REQ-031 SHALL present a FIFO entry to the consumer in the same cycle it is written when the FIFO was empty.
REQ-032 SHALL sustain one read per cycle with resp_ready held at 1, with first-read latency RD_LATENCY.
REQ-033 SHALL ignore address values at or above NUM_WORDS for writes.
REQ-034 SHALL return zero data for reads at address values at or above NUM_WORDS.
REQ-035 SHALL have read data undefined at addresses never written.

Reset
REQ-036 SHALL, on reset assertion, clear pipeline valid bits, FIFO pointers and the counter immediately.
REQ-037 SHALL drive resp_valid=0, out=0, resp_perr=0 and req_ready=1 after reset.
REQ-038 SHALL NOT clear memory contents on reset.
REQ-039 SHALL discard reads in flight at a mid-operation reset and never return them.

Configuration
REQ-040 SHALL, with SPRAM_PARITY_EN defined, store one even-parity bit per byte and update it on every enabled byte write.
REQ-041 SHALL, with SPRAM_PARITY_EN defined, have par_inject invert byte 0's stored parity when byte 0 is written.
REQ-042 SHALL, with SPRAM_PARITY_EN defined, assert resp_perr with a response if any byte's parity mismatches.
REQ-043 SHALL, without SPRAM_PARITY_EN, omit parity storage, tie resp_perr to 0 and ignore par_inject.

Structure
REQ-044 SHALL place the byte-lane count function, MAX_RD_LATENCY=4 and the even-parity function in a shared package, spram_pkg.
REQ-045 SHALL implement the response FIFO as sub-module spram_resp_fifo (parameters: width, depth).

Verification
REQ-046 SHALL test a write followed by a read: write addr 5 data 0xDEADBEEF byteen 0xF, read addr 5 -> out=0xDEADBEEF, RD_LATENCY cycles after acceptance.
REQ-047 SHALL test byte enables: write 0x11223344 to addr 5 with byteen 0x8 (byte 0 only) over 0xDEADBEEF -> read returns 0xDEADBE44.
REQ-048 SHALL test backpressure: RD_LATENCY=2, resp_ready=0, issue reads -> exactly 3 accepted, req_ready=0.
REQ-049 SHALL test backpressure release: from the REQ-048 state, raise resp_ready -> 3 responses in order, then full throughput.
REQ-050 SHALL test mid-operation reset: reset asserted with 2 reads in flight -> resp_valid=0 at once, no stale response afterwards, memory at addr 5 preserved.
REQ-051 SHALL test parity, with SPRAM_PARITY_EN: write addr 7 with par_inject=1, read addr 7 -> resp_perr=1; rewrite without injection -> resp_perr=0.
